// File: rtl/data_sram_confreg_pkg.sv
// Shared constants and helpers for the data-SRAM responder and its RAM bank.
// Holds the configuration-window offsets, the default window base and byte-lane merging.
package data_sram_confreg_pkg;

   localparam logic [15:0] CONF_BASE_DEFAULT = 16'hBFAF;

   localparam logic [15:0] LED_OFS     = 16'hF000;
   localparam logic [15:0] SWITCH_OFS  = 16'hF010;
   localparam logic [15:0] TIMER_OFS   = 16'hF020;
   localparam logic [15:0] NUM_OFS     = 16'hF030;
   localparam logic [15:0] SCRATCH_OFS = 16'hF040;

   function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  be);
      logic [31:0] r;
      r = old_w;
      for (int unsigned i = 0; i < 4; i++) begin
         if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/data_sram_confreg_sram_bank.sv
// Single-port read-first RAM with byte enables and one cycle of read latency.
// The read register only loads on enabled cycles, so it holds across idle cycles.
module sram_bank
   import data_sram_confreg_pkg::*;
#(
   parameter int unsigned AW = 14
) (
   input  logic          clk_i,
   input  logic          en_i,
   input  logic [3:0]    we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [2**AW];
   logic [31:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         rdata_q <= mem_q[addr_i];
         if (we_i != '0) mem_q[addr_i] <= merge_be(mem_q[addr_i], wdata_i, we_i);
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_confreg.sv
// Data-SRAM responder: config-window peripheral registers (LED, switch, timer, num,
// scratch) alongside a byte-writable RAM, all answering with one cycle of read latency.
module data_sram_confreg
   import data_sram_confreg_pkg::*;
#(
   parameter int unsigned RAM_AW    = 14,
   parameter logic [15:0] CONF_BASE = CONF_BASE_DEFAULT
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_we,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   input  logic [15:0] switch,
   output logic [15:0] led,
   output logic [31:0] num
);

   logic        conf_hit;
   logic [15:0] ofs;
   logic        conf_wr;
   logic        ram_en;
   logic [31:0] reg_rdata;
   logic [31:0] ram_rdata;
   logic [1:0]  unused_addr_lo;

   logic [15:0] led_q, led_d;
   logic [31:0] num_q, num_d;
   logic [31:0] scratch_q, scratch_d;
   logic [31:0] timer_q, timer_d;
   logic [15:0] sw_meta_q, sw_sync_q;
   logic        sel_conf_q;
   logic [31:0] reg_rdata_q;

   assign unused_addr_lo = data_sram_addr[1:0];

   always_comb begin
      conf_hit  = (data_sram_addr[31:16] == CONF_BASE);
      ofs       = data_sram_addr[15:0];
      conf_wr   = data_sram_en && conf_hit && (data_sram_we != '0);
      ram_en    = data_sram_en && !conf_hit && resetn;
      led_d     = led_q;
      num_d     = num_q;
      scratch_d = scratch_q;
      timer_d   = timer_q + 32'd1;
      reg_rdata = '0;
      case (ofs)
         LED_OFS: begin
            reg_rdata = {16'h0000, led_q};
            if (conf_wr) begin
               led_d[7:0]  = data_sram_we[0] ? data_sram_wdata[7:0]  : led_q[7:0];
               led_d[15:8] = data_sram_we[1] ? data_sram_wdata[15:8] : led_q[15:8];
            end
         end
         SWITCH_OFS: reg_rdata = {16'h0000, sw_sync_q};
         TIMER_OFS: begin
            reg_rdata = timer_q;
            if (conf_wr) timer_d = merge_be(timer_q, data_sram_wdata, data_sram_we);
         end
         NUM_OFS: begin
            reg_rdata = num_q;
            if (conf_wr) num_d = merge_be(num_q, data_sram_wdata, data_sram_we);
         end
         SCRATCH_OFS: begin
            reg_rdata = scratch_q;
            if (conf_wr) scratch_d = merge_be(scratch_q, data_sram_wdata, data_sram_we);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         led_q       <= '0;
         num_q       <= '0;
         scratch_q   <= '0;
         timer_q     <= '0;
         sw_meta_q   <= '0;
         sw_sync_q   <= '0;
         // Park the read mux on the zeroed register path so rdata reads 0
         // without needing a reset on the RAM output register.
         sel_conf_q  <= 1'b1;
         reg_rdata_q <= '0;
      end else begin
         led_q     <= led_d;
         num_q     <= num_d;
         scratch_q <= scratch_d;
         timer_q   <= timer_d;
         sw_meta_q <= switch;
         sw_sync_q <= sw_meta_q;
         if (data_sram_en) begin
            sel_conf_q  <= conf_hit;
            reg_rdata_q <= reg_rdata;
         end
      end
   end

   sram_bank #(
      .AW (RAM_AW)
   ) u_ram (
      .clk_i   (clk),
      .en_i    (ram_en),
      .we_i    (data_sram_we),
      .addr_i  (data_sram_addr[RAM_AW+1:2]),
      .wdata_i (data_sram_wdata),
      .rdata_o (ram_rdata)
   );

   assign data_sram_rdata = sel_conf_q ? reg_rdata_q : ram_rdata;
   assign led             = led_q;
   assign num             = num_q;

endmodule

// File: tb/tb_data_sram_confreg.sv
// Bench for data_sram_confreg: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_data_sram_confreg;

   localparam int unsigned AW = 14;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        en = 1'b0;
   logic [3:0]  we = '0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic [15:0] sw = '0;
   logic [15:0] led;
   logic [31:0] num;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   data_sram_confreg #(
      .RAM_AW    (AW),
      .CONF_BASE (16'hBFAF)
   ) dut (
      .clk             (clk),
      .resetn          (resetn),
      .data_sram_en    (en),
      .data_sram_we    (we),
      .data_sram_addr  (addr),
      .data_sram_wdata (wdata),
      .data_sram_rdata (rdata),
      .switch          (sw),
      .led             (led),
      .num             (num)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   bit [31:0] m_mem [int unsigned];
   bit [31:0] m_rdata;
   bit        m_known = 1'b0;
   bit        m_ready = 1'b0;
   bit [15:0] m_led;
   bit [31:0] m_num, m_scratch;
   bit [31:0] t_base;
   longint    t_edge = 0;
   longint    edge_n = 0;
   bit [15:0] sw_hist [$] = '{16'h0, 16'h0};

   function automatic bit [31:0] mmerge(bit [31:0] o, bit [31:0] n, bit [3:0] be);
      bit [31:0] res = 0;
      for (int b = 0; b < 4; b++)
         res = res | ((be[b] ? n : o) & (32'hFF << (8 * b)));
      return res;
   endfunction

   always @(posedge clk) begin
      bit [31:0] cur_t, pre, nw;
      bit [15:0] sw_pre, o;
      bit        hit, kn;
      int unsigned w;
      edge_n++;
      cur_t  = t_base + 32'(edge_n - 1 - t_edge);
      sw_pre = sw_hist[0];
      void'(sw_hist.pop_front());
      sw_hist.push_back(sw);
      if (!resetn) begin
         m_rdata = 0; m_known = 1; m_led = 0; m_num = 0; m_scratch = 0;
         t_base = 0; t_edge = edge_n;
         sw_hist = '{16'h0, 16'h0};
         m_ready = 1;
      end else if (en) begin
         hit = (addr[31:16] == 16'hBFAF);
         o   = addr[15:0];
         w   = addr[AW+1:2];
         kn  = 1;
         pre = 0;
         if (hit) begin
            case (o)
               16'hF000: pre = {16'h0, m_led};
               16'hF010: pre = {16'h0, sw_pre};
               16'hF020: pre = cur_t;
               16'hF030: pre = m_num;
               16'hF040: pre = m_scratch;
               default:  pre = 0;
            endcase
            if (we != 0) begin
               nw = mmerge(pre, wdata, we);
               case (o)
                  16'hF000: m_led = nw[15:0];
                  16'hF020: begin t_base = nw; t_edge = edge_n; end
                  16'hF030: m_num = nw;
                  16'hF040: m_scratch = nw;
                  default: ;
               endcase
            end
         end else begin
            if (m_mem.exists(w)) pre = m_mem[w];
            else kn = 0;
            if (we != 0) begin
               if (kn) m_mem[w] = mmerge(pre, wdata, we);
               else if (we == 4'hF) m_mem[w] = wdata;
            end
         end
         m_rdata = pre;
         m_known = kn;
      end
   end

   always @(negedge clk) begin
      if (m_ready) begin
         if (m_known) check("rdata_model", rdata, m_rdata);
         check("led_model", {16'h0, led}, {16'h0, m_led});
         check("num_model", num, m_num);
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input bit e, input bit [3:0] w, input bit [31:0] a, input bit [31:0] d);
      en = e; we = w; addr = a; wdata = d;
      @(negedge clk);
   endtask

   task automatic idle();
      drive(1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      logic [15:0] ofs_tab [8];
      int unsigned idx;
      ofs_tab = '{16'hF000, 16'hF010, 16'hF020, 16'hF030, 16'hF040, 16'hF050, 16'h0000, 16'hF004};
      a = $urandom;
      if ($urandom_range(0, 9) < 6) begin
         if (a[31:16] == 16'hBFAF) a[31] = 1'b0;
         idx = $urandom_range(0, 15);
         a[AW+1:2] = 14'(idx * 1031 + 16);
      end else begin
         a = {16'hBFAF, ofs_tab[$urandom_range(0, 7)]};
      end
      return a;
   endfunction

   initial begin
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_rdata", rdata, 32'h0);
      check("reset_led", {16'h0, led}, 32'h0);
      check("reset_num", num, 32'h0);
      resetn = 1'b1;

      repeat (10) idle();
      drive(1, 4'h0, 32'hBFAF_F020, 0);
      check("timer_at_10", rdata, 32'd10);

      drive(1, 4'hF, 32'h0000_0040, 32'h1234_5678);
      drive(1, 4'h0, 32'h0000_0040, 0);
      check("ram_roundtrip", rdata, 32'h1234_5678);
      drive(1, 4'b0101, 32'h0000_0040, 32'hAABB_CCDD);
      drive(1, 4'h0, 32'h0000_0040, 0);
      check("ram_byte_en", rdata, 32'h12BB_56DD);

      drive(1, 4'hF, 32'h0000_0080, 32'h1);
      drive(1, 4'hF, 32'h0000_0080, 32'h2);
      check("read_first", rdata, 32'h1);
      drive(1, 4'h0, 32'h0000_0080, 0);
      check("write_then_read", rdata, 32'h2);

      drive(1, 4'hF, 32'hBFAF_F020, 32'hFFFF_FFFF);
      drive(1, 4'h0, 32'hBFAF_F020, 0);
      check("timer_load", rdata, 32'hFFFF_FFFF);
      drive(1, 4'h0, 32'hBFAF_F020, 0);
      check("timer_wrap", rdata, 32'h0);

      drive(1, 4'hF, 32'hBFAF_F000, 32'h0001_A5A5);
      check("led_out", {16'h0, led}, 32'h0000_A5A5);
      drive(1, 4'h0, 32'hBFAF_F000, 0);
      check("led_read", rdata, 32'h0000_A5A5);

      sw = 16'h00F0;
      repeat (2) idle();
      drive(1, 4'h0, 32'hBFAF_F010, 0);
      check("switch_sync", rdata, 32'h0000_00F0);

      drive(1, 4'hF, 32'hBFAF_F050, 32'hDEAD_BEEF);
      drive(1, 4'h0, 32'hBFAF_F050, 0);
      check("unmapped_ofs", rdata, 32'h0);

      drive(1, 4'hF, 32'hBFAF_F030, 32'h0000_1234);
      check("num_out", num, 32'h0000_1234);
      resetn = 1'b0;
      drive(1, 4'hF, 32'hBFAF_F030, 32'hCAFE_0000);
      check("reset_drops_num", num, 32'h0);
      check("reset_rdata_mid", rdata, 32'h0);
      resetn = 1'b1;
      drive(1, 4'h0, 32'h0000_0040, 0);
      check("ram_survives_reset", rdata, 32'h12BB_56DD);

      for (int i = 0; i < 3000; i++) begin
         resetn = ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 15) == 0) sw = 16'($urandom);
         drive($urandom_range(0, 3) != 0,
               $urandom_range(0, 1) ? 4'h0 : 4'($urandom),
               rand_addr(), $urandom);
      end

      resetn = 1'b1;
      repeat (2) idle();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/data_sram_confreg.md
# data_sram_confreg

Responder for the CPU core's data SRAM port. Each cycle it accepts the core's en/we/addr/wdata request and returns read data exactly one cycle later. Addresses in the configuration window go to a small set of memory-mapped peripheral registers: LEDs, switches, free-running timer, display number and scratch. All other addresses go to an internal byte-writable RAM. It sits beside the core in the SoC top, connected directly to the core's data_sram_* ports.

## Interface
- RAM_AW, 14, RAM word-address width (RAM holds 2^RAM_AW 32-bit words)
- CONF_BASE, 16'hBFAF, value of addr[31:16] that selects the configuration window
- clk  input  1  single clock; all state changes on rising edge
- resetn  input  1  synchronous, active-low reset
- data_sram_en  input  1  request valid this cycle
- data_sram_we  input  4  byte write enables; 4'b0000 = read
- data_sram_addr  input  32  byte address; bits [1:0] ignored
- data_sram_wdata  input  32  write data, byte lanes gated by we
- data_sram_rdata  output  32  read data for the request of the previous cycle
- switch  input  16  board switches, asynchronous
- led  output  16  LED register value
- num  output  32  display-number register value

## Operation
- Decode: conf_hit = (addr[31:16] == CONF_BASE). Otherwise the request targets RAM word addr[RAM_AW+1:2]; higher address bits are ignored (aliasing).
- Config offsets use addr[15:0]:
  - 16'hF000 LED: RW, bits [15:0]; reads as {16'b0, led}.
  - 16'hF010 SWITCH: RO, {16'b0, switch_sync}.
  - 16'hF020 TIMER: RW, increments by 1 every cycle and wraps at 2^32.
  - 16'hF030 NUM: RW, 32 bits.
  - 16'hF040 SCRATCH: RW, 32 bits.
  - Any other offset: reads return 0, writes are ignored.
- Writes (en=1, we!=0): each byte lane i with we[i]=1 replaces that byte of the target. Other bytes are unchanged. Writes to SWITCH are ignored.
- TIMER write: the byte-merged value is loaded and overrides that cycle's increment. The next cycle's value is merged+1 only after a further cycle; a read in the cycle after the write returns merged.
- Read-first semantics: on any en=1 cycle, read or write, rdata is loaded with the target's value *before* that cycle's update. A TIMER read returns the pre-increment value.
- en=0: rdata holds its previous value, and no state changes except TIMER increment and the switch synchronizer.
- switch passes through a 2-flop synchronizer. switch_sync reflects a pin change 2 cycles later.

## Timing
- Read latency is exactly 1 cycle: request in cycle N, data_sram_rdata valid from the edge ending N through cycle N+1. The block never stalls.
- Back-to-back requests are accepted every cycle. A read in N+1 of an address written in N returns the new data.
- Reset (resetn=0 at an edge): rdata, led, num, scratch, timer and both sync flops are set to 0. RAM contents are not reset.
- Reset overrides any simultaneous request; a request in a reset cycle is dropped.
- led and num are direct register outputs and update the edge after the write.

## Structure
- Shared package data_sram_confreg_pkg holds:
  - offset localparams: LED_OFS, SWITCH_OFS, TIMER_OFS, NUM_OFS, SCRATCH_OFS
  - default CONF_BASE
  - byte-merge function merge_be(old, new, be)
- Sub-module sram_bank: single-port, read-first, 1-cycle-latency RAM with 4-bit byte enables, parameter AW. It is instantiated once for the RAM region.
- Top level contains:
  - the decode
  - the peripheral registers
  - the timer
  - the synchronizer
  - a registered select that muxes RAM output vs register read data into rdata (registered conf_hit plus the registered register-read value)

## Test plan
- RAM round trip: write 0x12345678 to 0x0000_0040 with we=4'hF, then read the same address → rdata=0x12345678 in the cycle after the read.
- Byte enables: with the word holding 0x12345678, write 0xAABBCCDD with we=4'b0101 → a subsequent read returns 0x12BB56DD.
- Read-first: write 0x1 then write 0x2 to the same address in consecutive cycles → rdata after the second write = 0x1.
- Timer: after reset, read 0xBFAF_F020 at cycle 10 → 10. Write 0xFFFFFFFF, then read the next cycle → 0xFFFFFFFF; read one cycle later → 0 (wrap).
- Peripherals: write 0xBFAF_F000 with 0x0001A5A5 → led=0xA5A5, and a read returns 0x0000A5A5. Set switch=0x00F0 → a SWITCH read issued ≥2 cycles later returns 0xF0. Reading offset 0xF050 → 0.
- Reset mid-operation: issue a write to NUM together with resetn=0 → num=0 and rdata=0 after the edge. RAM data written before reset is still readable.
